mac_tcdm_responder: RTL

//  Multi-port TCDM slave answering the MP hwpe_stream_intf_tcdm master ports of the MAC accelerator.

---
 rtl/mac_package.sv | 15 +
 rtl/mac_tcdm_rr_arbiter.sv | 46 ++++
 rtl/mac_tcdm_responder.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/mac_package.sv
// Shared constants and helpers for the MAC accelerator memory-side blocks.
// Covers TCDM bus widths and the stall LFSR seed and step.
package mac_package;

   localparam int unsigned TCDM_ADDR_W = 32;
   localparam int unsigned TCDM_DATA_W = 32;
   localparam int unsigned TCDM_BE_W   = 4;
   localparam logic [15:0] LFSR_SEED   = 16'hACE1;

   // Fibonacci step for x^16+x^14+x^13+x^11+1, shifting towards bit 0.
   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
   endfunction

endpackage

// File: rtl/mac_tcdm_rr_arbiter.sv
// Round-robin arbiter for one bank: MP requests in, one-hot grant out.
// The pointer names the highest-priority port and moves past each winner.
module mac_tcdm_rr_arbiter #(
   parameter int unsigned MP = 4
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          clear_i,
   input  logic          en,
   input  logic [MP-1:0] req,
   output logic [MP-1:0] gnt
);

   localparam int unsigned PTR_W = (MP > 1) ? $clog2(MP) : 1;

   logic [PTR_W-1:0] ptr_q;
   logic [PTR_W-1:0] ptr_d;
   logic [PTR_W-1:0] idx;
   int unsigned      idx_full;
   logic             found;

   always_comb begin
      gnt      = '0;
      ptr_d    = ptr_q;
      found    = 1'b0;
      idx_full = 0;
      idx      = '0;
      for (int unsigned i = 0; i < MP; i++) begin
         idx_full = 32'(ptr_q) + i;
         if (idx_full >= MP) idx_full = idx_full - MP;
         idx = PTR_W'(idx_full);
         if (en && !found && req[idx]) begin
            found    = 1'b1;
            gnt[idx] = 1'b1;
            ptr_d    = (idx_full + 1 == MP) ? '0 : PTR_W'(idx_full + 1);
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)        ptr_q <= '0;
      else if (clear_i) ptr_q <= '0;
      else              ptr_q <= ptr_d;
   end

endmodule

// File: rtl/mac_tcdm_responder.sv
// Multi-port word-interleaved TCDM slave: banked single-port memories,
// per-bank round-robin grants, optional LFSR grant stalls, conflict counter.
module mac_tcdm_responder
   import mac_package::*;
#(
   parameter int unsigned MP      = 4,
   parameter int unsigned N_BANKS = 4,
   parameter int unsigned DEPTH   = 1024
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic                            stall_en_i,
   input  logic                            clear_i,
   input  logic [MP-1:0]                   tcdm_req,
   output logic [MP-1:0]                   tcdm_gnt,
   input  logic [MP-1:0][TCDM_ADDR_W-1:0]  tcdm_add,
   input  logic [MP-1:0]                   tcdm_wen,
   input  logic [MP-1:0][TCDM_BE_W-1:0]    tcdm_be,
   input  logic [MP-1:0][TCDM_DATA_W-1:0]  tcdm_data,
   output logic [MP-1:0][TCDM_DATA_W-1:0]  tcdm_r_data,
   output logic [MP-1:0]                   tcdm_r_valid,
   output logic [31:0]                     conflicts_o
);

   // Handshake: a request transfers in the cycle where req and gnt are both 1;
   // an ungranted master holds req/add/wen/be/data. Reads return r_valid with
   // r_data exactly one cycle after the grant; writes never return r_valid.

   localparam int unsigned BANK_W   = (N_BANKS > 1) ? $clog2(N_BANKS) : 1;
   localparam int unsigned BANK_LOG = $clog2(N_BANKS);
   localparam int unsigned ROW_W    = $clog2(DEPTH);
   localparam int unsigned CNT_W    = $clog2(MP + 1);

   logic [MP-1:0][BANK_W-1:0]               port_bank;
   logic [MP-1:0][ROW_W-1:0]                port_row;
   logic [N_BANKS-1:0][MP-1:0]              bank_gnt;
   logic [N_BANKS-1:0][TCDM_DATA_W-1:0]     bank_rdata;
   logic [15:0]                             lfsr_q;
   logic [MP-1:0]                           rvalid_q;
   logic [MP-1:0][BANK_W-1:0]               bsel_q;
   logic [MP-1:0][TCDM_DATA_W-1:0]          hold_q;
   logic [CNT_W-1:0]                        miss_cnt;
   logic [32:0]                             conf_sum;
   logic [31:0]                             conflicts_q;
   logic                                    unused_addr;

   assign unused_addr = ^tcdm_add;

   always_comb begin
      for (int p = 0; p < MP; p++) begin
         port_bank[p] = (N_BANKS > 1) ? tcdm_add[p][2 +: BANK_W] : '0;
         port_row[p]  = tcdm_add[p][2 + BANK_LOG +: ROW_W];
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) lfsr_q <= LFSR_SEED;
      else       lfsr_q <= lfsr_next(lfsr_q);
   end

   for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
      logic [TCDM_DATA_W-1:0] mem [DEPTH];
      logic [TCDM_DATA_W-1:0] rdata_q;
      logic [MP-1:0]          req_b;
      logic                   en_b;
      logic                   win_any;
      logic                   win_wen;
      logic [ROW_W-1:0]       win_row;
      logic [TCDM_BE_W-1:0]   win_be;
      logic [TCDM_DATA_W-1:0] win_data;

      always_comb begin
         req_b = '0;
         for (int p = 0; p < MP; p++)
            req_b[p] = tcdm_req[p] && (port_bank[p] == BANK_W'(b));
      end

      // Nothing is granted while reset is high, so reset-cycle writes are dropped.
      assign en_b = !rst_i && !(stall_en_i && lfsr_q[b % 16]);

      mac_tcdm_rr_arbiter #(.MP(MP)) u_arb (
         .clk_i   (clk_i),
         .rst_i   (rst_i),
         .clear_i (clear_i),
         .en      (en_b),
         .req     (req_b),
         .gnt     (bank_gnt[b])
      );

      always_comb begin
         win_any  = 1'b0;
         win_wen  = 1'b0;
         win_row  = '0;
         win_be   = '0;
         win_data = '0;
         for (int p = 0; p < MP; p++) begin
            if (bank_gnt[b][p]) begin
               win_any  = 1'b1;
               win_wen  = tcdm_wen[p];
               win_row  = port_row[p];
               win_be   = tcdm_be[p];
               win_data = tcdm_data[p];
            end
         end
      end

      always_ff @(posedge clk_i) begin
         if (win_any && !win_wen) begin
            for (int i = 0; i < TCDM_BE_W; i++)
               if (win_be[i]) mem[win_row][8*i +: 8] <= win_data[8*i +: 8];
         end
         if (win_any && win_wen) rdata_q <= mem[win_row];
      end

      assign bank_rdata[b] = rdata_q;
   end

   always_comb begin
      tcdm_gnt = '0;
      for (int b = 0; b < N_BANKS; b++)
         for (int p = 0; p < MP; p++)
            tcdm_gnt[p] = tcdm_gnt[p] | bank_gnt[b][p];
   end

   // hold_q keeps the last returned word so r_data is stable between responses.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rvalid_q <= '0;
         bsel_q   <= '0;
         hold_q   <= '0;
      end else begin
         for (int p = 0; p < MP; p++) begin
            rvalid_q[p] <= tcdm_gnt[p] & tcdm_wen[p];
            if (tcdm_gnt[p] && tcdm_wen[p]) bsel_q[p] <= port_bank[p];
            if (rvalid_q[p]) hold_q[p] <= bank_rdata[bsel_q[p]];
         end
      end
   end

   always_comb begin
      for (int p = 0; p < MP; p++)
         tcdm_r_data[p] = rvalid_q[p] ? bank_rdata[bsel_q[p]] : hold_q[p];
   end

   assign tcdm_r_valid = rvalid_q;

   always_comb begin
      miss_cnt = '0;
      for (int p = 0; p < MP; p++)
         miss_cnt = miss_cnt + CNT_W'(tcdm_req[p] & ~tcdm_gnt[p]);
   end

   assign conf_sum = {1'b0, conflicts_q} + 33'(miss_cnt);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)            conflicts_q <= '0;
      else if (clear_i)     conflicts_q <= '0;
      else if (conf_sum[32]) conflicts_q <= '1;
      else                  conflicts_q <= conf_sum[31:0];
   end

   assign conflicts_o = conflicts_q;

endmodule
